// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch unit: widths, reset PC, instruction field positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // RISC-V base encoding field positions within an instruction word
  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect input, decode handshake and fields.
// Latency: n/a (wires only). Optional FETCH_MISALIGN_TRAP_EN adds misalign_trap/misalign_addr.
// Backpressure: imem_req_ready and dec_ready stall the producer; responses are never stalled.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      Op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_trap;
  logic [XLEN-1:0] misalign_addr;
`endif

  // fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output dec_valid, dec_instr, dec_pc, Op, funct3, funct7,
`ifdef FETCH_MISALIGN_TRAP_EN
    output misalign_trap, misalign_addr,
`endif
    input  dec_ready
  );

  // memory / execute / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, Op, funct3, funct7,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  misalign_trap, misalign_addr,
`endif
    output dec_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Fetch buffer: synchronous FIFO with flush, head shown combinationally, count/full/empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module instr_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  // pointers and occupancy; flush wins over any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage needs no reset: it is only observed behind a non-zero count
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC, issues in-order imem requests, buffers words for decode; macro FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap.
// Latency: accept -> dec_valid in 2 cycles with 1-cycle memory; one idle cycle after reset.
// Backpressure: requests stop once outstanding + buffered reaches FIFO_DEPTH; redirect flushes and drains stale responses.
module instr_fetch_unit #(
  parameter int XLEN = instr_fetch_unit_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  import instr_fetch_unit_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, redirect_pc_aligned;
  logic [CW-1:0]   outstanding, outstanding_nxt, drop_cnt, drop_cnt_nxt, pending;
  logic            accept, rsp_hit, rsp_drop, fifo_push, fifo_pop;
  logic [XLEN-1:0] rq_pc [FIFO_DEPTH];
  logic [AW-1:0]   rq_wr, rq_rd;
  logic [2*XLEN-1:0] fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty, full_unused;
  logic [XLEN-1:0] head_instr;

  assign redirect_pc_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign accept   = bus.imem_req_valid & bus.imem_req_ready;
  // a response with nothing outstanding is spurious and ignored
  assign rsp_hit  = bus.imem_rsp_valid & (state == RUN) & (outstanding != '0);
  assign rsp_drop = bus.imem_rsp_valid & (state == FLUSH) & (drop_cnt != '0);
  // live requests still owed by memory once this cycle's accept/response settle
  assign pending  = outstanding + CW'(accept) - CW'(rsp_hit);

  assign bus.imem_req_valid = (state == RUN) &&
                              (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;

  // next-state, PC and credit bookkeeping
  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    pc_nxt          = pc;
    if (accept)       pc_nxt = pc + XLEN'(4);
    if (bus.redirect) pc_nxt = redirect_pc_aligned;
    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.redirect) begin
          outstanding_nxt = '0;
          if (pending != '0) begin
            state_nxt    = FLUSH;
            drop_cnt_nxt = pending;
          end
        end else begin
          outstanding_nxt = pending;
        end
      end
      FLUSH: begin
        drop_cnt_nxt = drop_cnt - CW'(rsp_drop);
        if (drop_cnt_nxt == '0) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, PC and credit counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // request-PC queue pointers: one entry per live outstanding request, oldest first
  always_ff @(posedge clk) begin
    if (!rst || bus.redirect) begin
      rq_wr <= '0;
      rq_rd <= '0;
    end else begin
      if (accept)  rq_wr <= rq_wr + AW'(1);
      if (rsp_hit) rq_rd <= rq_rd + AW'(1);
    end
  end

  // request-PC storage; requests accepted alongside a redirect are stale and not recorded
  always_ff @(posedge clk) begin
    if (accept && !bus.redirect) rq_pc[rq_wr] <= pc;
  end

  assign fifo_push = rsp_hit & ~bus.redirect;
  assign fifo_pop  = bus.dec_valid & bus.dec_ready;

  instr_fetch_unit_fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push     (fifo_push),
    .push_dat ({bus.imem_rsp_data, rq_pc[rq_rd]}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // overflow is already impossible through the credit check on requests
  assign full_unused = fifo_full;

  assign bus.dec_valid = ~fifo_empty;
  assign head_instr    = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
  assign bus.dec_instr = head_instr;
  assign bus.dec_pc    = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign bus.Op        = head_instr[OP_MSB:OP_LSB];
  assign bus.funct3    = head_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign bus.funct7    = head_instr[FUNCT7_MSB:FUNCT7_LSB];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            trap_q;
  logic [XLEN-1:0] trap_addr_q;

  // one-cycle trap pulse and capture of the offending target
  always_ff @(posedge clk) begin
    if (!rst) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q <= bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) trap_addr_q <= bus.redirect_pc;
    end
  end

  assign bus.misalign_trap = trap_q;
  assign bus.misalign_addr = trap_addr_q;
`else
  // low target bits are silently masked
  logic lsb_unused;
  assign lsb_unused = ^bus.redirect_pc[1:0];
`endif

endmodule
